// File: rtl/si534x_config_sequencer.sv
// Walks a register ROM and programs up to NUM_DEV Si534x parts through a byte-level I2C controller.
// Build option: define SI534X_VERIFY_EN to read back and compare every register write.
module si534x_config_sequencer #(
  parameter int                   NUM_DEV    = 2,
  parameter logic [NUM_DEV*7-1:0] DEV_ADDR   = {7'h75, 7'h74},
  parameter int                   ROM_LEN    = 512,
  parameter int                   ROM_AW     = $clog2(ROM_LEN),
  parameter int                   CLK_PER_NS = 8,
  parameter int                   PAUSE_NS   = 300_000_000
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic               load_i,
  input  logic [NUM_DEV-1:0] dev_mask_i,
  output logic [ROM_AW-1:0]  rom_addr_o,
  input  logic [23:0]        rom_data_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic               cmd_start_o,
  output logic               cmd_stop_o,
  output logic               cmd_read_o,
  output logic [7:0]         cmd_data_o,
  input  logic               rsp_valid_i,
  input  logic               rsp_nack_i,
  input  logic [7:0]         rsp_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [2:0]         err_dev_o,
  output logic [ROM_AW-1:0]  err_idx_o,
  output logic [3:0]         dbg_state_o
);

  localparam int              PAUSE_CYC = (PAUSE_NS + CLK_PER_NS - 1) / CLK_PER_NS;
  localparam logic [31:0]     PAUSE_LD  = 32'(PAUSE_CYC - 1);
  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(ROM_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_SEL_DEV = 4'd1, S_FETCH = 4'd2, S_DECODE = 4'd3, S_PAGE_TX = 4'd4,
    S_REG_TX = 4'd5, S_VERIFY_TX = 4'd6, S_PAUSE = 4'd7, S_STOP_TX = 4'd8, S_DONE = 4'd9
  } state_t;

  state_t              r_state;
  logic [NUM_DEV-1:0]  r_mask;
  logic [2:0]          r_dev;
  logic [ROM_AW-1:0]   r_index;
  logic                r_cache_vld;
  logic [7:0]          r_cache_page, r_page, r_reg, r_data;
  logic [1:0]          r_byte;
  logic                r_out;
  logic [31:0]         r_cnt;
  logic                r_cmd_valid, r_cmd_start, r_cmd_stop;
  logic [7:0]          r_cmd_data;
  logic                r_busy, r_done, r_err;
  logic [2:0]          r_err_dev;
  logic [ROM_AW-1:0]   r_err_idx;

  logic                w_found;
  logic [2:0]          w_next;
  logic [NUM_DEV-1:0]  w_rest;
  logic [6:0]          w_addr;
  logic                w_start, w_stop, w_read, w_mismatch;
  logic [7:0]          w_data;
  logic [1:0]          w_last;

  // Lowest remaining device in the latched mask, and the mask with that bit cleared.
  always_comb begin
    w_found = 1'b0;
    w_next  = 3'd0;
    w_rest  = r_mask;
    w_addr  = DEV_ADDR[6:0];
    for (int i = 0; i < NUM_DEV; i++) begin
      if (r_mask[i] && !w_found) begin
        w_found   = 1'b1;
        w_next    = 3'(i);
        w_rest[i] = 1'b0;
      end
      if (r_dev == 3'(i)) w_addr = DEV_ADDR[i*7 +: 7];
    end
  end

  always_comb begin
    w_start = 1'b0;
    w_stop  = 1'b0;
    w_read  = 1'b0;
    w_data  = 8'h00;
    w_last  = 2'd2;
    case (r_state)
      S_PAGE_TX, S_REG_TX: begin
        case (r_byte)
          2'd0:    begin w_start = 1'b1; w_data = {w_addr, 1'b0}; end
          2'd1:    w_data = (r_state == S_PAGE_TX) ? 8'h01 : r_reg;
          default: begin w_stop = 1'b1; w_data = (r_state == S_PAGE_TX) ? r_page : r_data; end
        endcase
      end
`ifdef SI534X_VERIFY_EN
      S_VERIFY_TX: begin
        w_last = 2'd3;
        case (r_byte)
          2'd0:    begin w_start = 1'b1; w_data = {w_addr, 1'b0}; end
          2'd1:    w_data = r_reg;
          2'd2:    begin w_start = 1'b1; w_data = {w_addr, 1'b1}; end
          default: begin w_read = 1'b1; w_stop = 1'b1; end
        endcase
      end
`endif
      S_STOP_TX: begin w_stop = 1'b1; w_data = 8'hFF; w_last = 2'd0; end
      default: ;
    endcase
  end

`ifdef SI534X_VERIFY_EN
  assign w_mismatch = (r_state == S_VERIFY_TX) && w_read && (rsp_data_i != r_data);
`else
  logic w_unused_rsp;
  assign w_mismatch   = 1'b0;
  assign w_unused_rsp = ^rsp_data_i;
`endif

  // Handshake: a command is transferred on a cycle with cmd_valid_o && cmd_ready_i; fields hold
  // while valid is unanswered, and the next command is raised only after rsp_valid_i for this one.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= S_IDLE;       r_mask <= '0;          r_dev <= 3'd0;
      r_index <= '0;           r_cache_vld <= 1'b0;   r_cache_page <= 8'h00;
      r_page <= 8'h00;         r_reg <= 8'h00;        r_data <= 8'h00;
      r_byte <= 2'd0;          r_out <= 1'b0;         r_cnt <= 32'd0;
      r_cmd_valid <= 1'b0;     r_cmd_start <= 1'b0;   r_cmd_stop <= 1'b0;
      r_cmd_data <= 8'h00;     r_busy <= 1'b0;        r_done <= 1'b0;
      r_err <= 1'b0;           r_err_dev <= 3'd0;     r_err_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_cmd_valid && cmd_ready_i) r_cmd_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (load_i) begin
          r_mask    <= dev_mask_i;
          r_busy    <= 1'b1;
          r_err     <= 1'b0;
          r_err_dev <= 3'd0;
          r_err_idx <= '0;
          r_state   <= S_SEL_DEV;
        end
        S_SEL_DEV: if (w_found) begin
          r_dev       <= w_next;
          r_mask      <= w_rest;
          r_index     <= '0;
          r_cache_vld <= 1'b0;
          r_state     <= S_FETCH;
        end else begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_page <= rom_data_i[23:16];
          r_reg  <= rom_data_i[15:8];
          r_data <= rom_data_i[7:0];
          r_byte <= 2'd0;
          r_out  <= 1'b0;
          if (rom_data_i[23:8] == 16'hFFFF) begin
            r_cnt   <= PAUSE_LD;
            r_state <= S_PAUSE;
          end else if (!r_cache_vld || rom_data_i[23:16] != r_cache_page) r_state <= S_PAGE_TX;
          else r_state <= S_REG_TX;
        end
        S_PAUSE: if (r_cnt == 32'd0) begin
          if (r_index == LAST_IDX) r_state <= S_SEL_DEV;
          else begin r_index <= r_index + 1'b1; r_state <= S_FETCH; end
        end else r_cnt <= r_cnt - 32'd1;
        S_PAGE_TX, S_REG_TX, S_VERIFY_TX, S_STOP_TX: begin
          if (!r_out) begin
            r_cmd_valid <= 1'b1;
            r_cmd_start <= w_start;
            r_cmd_stop  <= w_stop;
            r_cmd_data  <= w_data;
            r_out       <= 1'b1;
          end else if (rsp_valid_i && (!r_cmd_valid || cmd_ready_i)) begin
            r_out <= 1'b0;
            if (r_state == S_STOP_TX) begin
              r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_DONE;
            end else if ((!w_read && rsp_nack_i) || w_mismatch) begin
              if (!r_err) begin r_err <= 1'b1; r_err_dev <= r_dev; r_err_idx <= r_index; end
              r_byte <= 2'd0;
              // A read mismatch leaves the bus already stopped; a NACK needs an explicit STOP.
              if (w_mismatch) begin r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_DONE; end
              else r_state <= S_STOP_TX;
            end else if (r_byte != w_last) r_byte <= r_byte + 2'd1;
            else begin
              r_byte <= 2'd0;
              case (r_state)
                S_PAGE_TX: begin
                  r_cache_page <= r_page;
                  r_cache_vld  <= 1'b1;
                  r_state      <= S_REG_TX;
                end
`ifdef SI534X_VERIFY_EN
                S_REG_TX: r_state <= S_VERIFY_TX;
`endif
                default: begin
                  if (r_index == LAST_IDX) r_state <= S_SEL_DEV;
                  else begin r_index <= r_index + 1'b1; r_state <= S_FETCH; end
                end
              endcase
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SI534X_VERIFY_EN
  logic r_cmd_read;
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_cmd_read <= 1'b0;
    else if (!r_out && (r_state == S_VERIFY_TX)) r_cmd_read <= w_read;
    else if (!r_out && (r_state inside {S_PAGE_TX, S_REG_TX, S_STOP_TX})) r_cmd_read <= 1'b0;
  end
  assign cmd_read_o = r_cmd_read;
`else
  assign cmd_read_o = 1'b0;
`endif

  assign rom_addr_o  = r_index;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_start_o = r_cmd_start;
  assign cmd_stop_o  = r_cmd_stop;
  assign cmd_data_o  = r_cmd_data;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign err_dev_o   = r_err_dev;
  assign err_idx_o   = r_err_idx;
  assign dbg_state_o = r_state;

endmodule
